// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
//   Shared definitions for the iterative multiply/divide unit:
//     - MDControl operation encodings (md_op_e)
//     - FSM state encodings (md_state_e)
//     - default operand width and iteration-counter width helper
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } md_state_e;

    // Iteration counter width: counts 0..w-1, one step per operand bit.
    function automatic int md_cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
//   Combinational conditional two's-complement negate. Used both to take the
//   magnitude of signed operands on launch and to restore the sign of the
//   result before commit.
//   Ports:
//     neg   in   1      1 = output -din (modulo 2^WIDTH), 0 = pass through
//     din   in   WIDTH  value to fix
//     dout  out  WIDTH  fixed value
// -----------------------------------------------------------------------------
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit owning the HI/LO registers.
//   MULT/MULTU use shift-add over a 2*WIDTH accumulator, DIV/DIVU use restoring
//   division; both retire one bit per clock, WIDTH iterations, then a sign-fix
//   and commit cycle. Start edge to HI/LO update is WIDTH+1 edges.
//   Ports:
//     CLK        in   1      clock
//     RST        in   1      asynchronous active-low reset
//     Start      in   1      launch op (honoured only while idle)
//     MDControl  in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     OP_A       in   WIDTH  multiplicand / dividend, also MTHI/MTLO data
//     OP_B       in   WIDTH  multiplier / divisor
//     HI_WE      in   1      MTHI write strobe (idle only)
//     LO_WE      in   1      MTLO write strobe (idle only)
//     HI         out  WIDTH  product high half / remainder
//     LO         out  WIDTH  product low half / quotient
//     Busy       out  1      op in flight
//     Done       out  1      one-cycle pulse after HI/LO commit
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [1:0]       MDControl,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             HI_WE,
    input  logic             LO_WE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done
);

    localparam int             CW   = md_cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    md_state_e          state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    md_op_e             op_reg;
    logic [WIDTH-1:0]   b_mag_reg;
    logic [WIDTH-1:0]   a_raw_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               div_zero_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg;

    // ---------------- launch-time operand capture ----------------
    md_op_e           op_in;
    logic             in_signed;
    logic             in_div;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_in     = md_op_e'(MDControl);
    assign in_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
    assign in_div    = (op_in == MD_DIV)  || (op_in == MD_DIVU);

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_a (
        .neg (in_signed & OP_A[WIDTH-1]),
        .din (OP_A),
        .dout(a_mag)
    );

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_b (
        .neg (in_signed & OP_B[WIDTH-1]),
        .din (OP_B),
        .dout(b_mag)
    );

    // ---------------- iteration datapath ----------------
    logic             is_div;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    assign is_div = (op_reg == MD_DIV) || (op_reg == MD_DIVU);

    // Shift-add: multiplier sits in the low half and is consumed LSB first;
    // the carry of the add lands in the top bit after the right shift.
    assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                   + (acc_reg[0] ? {1'b0, b_mag_reg} : '0);

    // Restoring divide: shift the next dividend bit into the partial
    // remainder and try subtracting the divisor. The partial remainder is
    // always below the divisor, so a trial fits in WIDTH+1 bits and the
    // borrow is the top bit of the difference.
    assign div_trial = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, b_mag_reg};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];

    // ---------------- result sign correction ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .neg (neg_q_reg),
        .din (acc_reg),
        .dout(prod_fix)
    );

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
        .neg (neg_q_reg),
        .din (acc_reg[WIDTH-1:0]),
        .dout(quot_fix)
    );

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .neg (neg_r_reg),
        .din (acc_reg[2*WIDTH-1:WIDTH]),
        .dout(rem_fix)
    );

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero_reg) begin
                // Divide by zero bypasses the magnitude path entirely.
                res_hi = a_raw_reg;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quot_fix;
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (Start)           state_next = ST_RUN;
            ST_RUN:  if (cnt_reg == LAST) state_next = ST_FIN;
            ST_FIN:                       state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath and HI/LO registers ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_reg      <= '0;
            op_reg       <= MD_MULT;
            b_mag_reg    <= '0;
            a_raw_reg    <= '0;
            acc_reg      <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= (state_reg == ST_FIN);
            case (state_reg)
                ST_IDLE: begin
                    if (Start) begin
                        // Start takes priority; a coincident MTHI/MTLO is dropped.
                        op_reg       <= op_in;
                        b_mag_reg    <= b_mag;
                        a_raw_reg    <= OP_A;
                        acc_reg      <= {{WIDTH{1'b0}}, a_mag};
                        cnt_reg      <= '0;
                        neg_q_reg    <= in_signed & (OP_A[WIDTH-1] ^ OP_B[WIDTH-1]);
                        neg_r_reg    <= in_signed & OP_A[WIDTH-1];
                        div_zero_reg <= in_div & (OP_B == '0);
                    end else begin
                        if (HI_WE) hi_reg <= OP_A;
                        if (LO_WE) lo_reg <= OP_A;
                    end
                end
                ST_RUN: begin
                    acc_reg <= is_div ? {div_rem, acc_reg[WIDTH-2:0], div_ge}
                                      : {mul_sum, acc_reg[WIDTH-1:1]};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                ST_FIN: begin
                    hi_reg <= res_hi;
                    lo_reg <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state_reg != ST_IDLE);
    assign Done = done_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit. Expected HI/LO come from a 64-bit
//   arithmetic reference model; latency and Busy duration are checked for
//   every operation.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [1:0]  MDControl;
    logic [31:0] OP_A, OP_B;
    logic        HI_WE, LO_WE;
    logic [31:0] HI, LO;
    logic        Busy, Done;

    always #5 CLK = ~CLK;

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Start    (Start),
        .MDControl(MDControl),
        .OP_A     (OP_A),
        .OP_B     (OP_B),
        .HI_WE    (HI_WE),
        .LO_WE    (LO_WE),
        .HI       (HI),
        .LO       (LO),
        .Busy     (Busy),
        .Done     (Done)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc;
    int          busy_cnt;
    logic [31:0] exp_hi, exp_lo;
    logic [31:0] cur_a, cur_b;
    logic [1:0]  cur_op;
    logic [31:0] prev_hi;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic following the ISA result rules.
    task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                p  = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (op == 2'b10) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic step();
        tick();
        cyc++;
        busy_cnt += Busy ? 1 : 0;
    endtask

    // Drive Start for one cycle; operands are scrambled afterwards so the
    // DUT must have latched them.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        ref_model(op, a, b, exp_hi, exp_lo);
        cur_op    = op;
        cur_a     = a;
        cur_b     = b;
        MDControl = op;
        OP_A      = a;
        OP_B      = b;
        Start     = 1'b1;
        tick();
        Start     = 1'b0;
        OP_A      = $urandom;
        OP_B      = $urandom;
        MDControl = 2'($urandom);
        cyc       = 1;
        busy_cnt  = Busy ? 1 : 0;
    endtask

    // Wait (bounded) for Done and check latency, Busy duration and result.
    task automatic finish_op(input string tag);
        while (!Done && cyc < 60) step();
        check_val({tag, "/latency"}, cyc, 32'd34);
        check_val({tag, "/busy"}, busy_cnt, 32'd33);
        check_val({tag, "/HI"}, HI, exp_hi);
        check_val({tag, "/LO"}, LO, exp_lo);
        $display("%s op=%0d a=%08h b=%08h -> HI=%08h LO=%08h (exp %08h %08h) lat=%0d",
                 tag, cur_op, cur_a, cur_b, HI, LO, exp_hi, exp_lo, cyc);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    logic [1:0]  dir_op [8] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
    logic [31:0] dir_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                                32'd7, 32'd7, 32'h8000_0000, 32'd5};
    logic [31:0] dir_b  [8] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                                32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};

    initial begin
        RST = 1'b0; Start = 1'b0; HI_WE = 1'b0; LO_WE = 1'b0;
        MDControl = 2'b00; OP_A = '0; OP_B = '0;
        cyc = 0; busy_cnt = 0;

        // Reset state
        repeat (3) tick();
        check_val("reset/HI", HI, 32'd0);
        check_val("reset/LO", LO, 32'd0);
        check_val("reset/Busy", {31'b0, Busy}, 32'd0);
        check_val("reset/Done", {31'b0, Done}, 32'd0);
        RST = 1'b1;
        tick();

        // MTHI / MTLO while idle
        HI_WE = 1'b1; OP_A = 32'hCAFE_0001;
        tick();
        HI_WE = 1'b0;
        check_val("mthi", HI, 32'hCAFE_0001);
        LO_WE = 1'b1; OP_A = 32'h0BAD_0002;
        tick();
        LO_WE = 1'b0;
        check_val("mtlo", LO, 32'h0BAD_0002);
        $display("mt writes HI=%08h LO=%08h", HI, LO);

        // Start together with HI_WE: start wins, MTHI dropped
        prev_hi = HI;
        HI_WE = 1'b1;
        launch(2'b01, 32'd3, 32'd5);
        HI_WE = 1'b0;
        check_val("start_vs_mthi", HI, prev_hi);
        finish_op("start_vs_mthi");

        // Directed corner cases, launched back-to-back in each Done cycle
        for (int i = 0; i < 8; i++) begin
            launch(dir_op[i], dir_a[i], dir_b[i]);
            finish_op($sformatf("dir%0d", i));
        end

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            launch(2'($urandom), rand_operand(), rand_operand());
            finish_op($sformatf("rnd%0d", i));
        end

        // Start, HI_WE, LO_WE pulsed at iteration 10 are ignored
        launch(2'b01, $urandom, $urandom);
        repeat (9) step();
        Start = 1'b1; HI_WE = 1'b1; LO_WE = 1'b1;
        MDControl = 2'b10; OP_A = $urandom; OP_B = $urandom;
        step();
        Start = 1'b0; HI_WE = 1'b0; LO_WE = 1'b0;
        finish_op("midop");

        // MTLO in the Done cycle
        LO_WE = 1'b1; OP_A = 32'h0000_1234;
        tick();
        LO_WE = 1'b0;
        check_val("done_mtlo/LO", LO, 32'h0000_1234);
        check_val("done_mtlo/HI", HI, exp_hi);
        check_val("done_mtlo/Busy", {31'b0, Busy}, 32'd0);
        $display("done-cycle mtlo HI=%08h LO=%08h", HI, LO);

        // Reset at iteration 10 aborts the op
        launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) step();
        RST = 1'b0;
        #1;
        check_val("midrst/Busy", {31'b0, Busy}, 32'd0);
        check_val("midrst/Done", {31'b0, Done}, 32'd0);
        check_val("midrst/HI", HI, 32'd0);
        check_val("midrst/LO", LO, 32'd0);
        $display("mid-op reset HI=%08h LO=%08h Busy=%0b", HI, LO, Busy);
        #2;
        RST = 1'b1;
        tick();
        check_val("postrst/Busy", {31'b0, Busy}, 32'd0);
        check_val("postrst/LO", LO, 32'd0);
        launch(2'b01, 32'd6, 32'd7);
        finish_op("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
